// File: rtl/mem_arbiter.sv
// Shares one off-chip memory port between the icache and dcache.
// Requests are queued per requester, granted round-robin, and one memory op is kept in flight at a time.
module mem_arbiter #(
    parameter int QDEPTH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_ren,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_rec_en,
    output logic [ADDR_W-1:0] ic_rec_addr,
    output logic [LINE_W-1:0] ic_rec_cacheline,
    input  logic              dc_req_ren,
    input  logic              dc_req_wen,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_cacheline,
    output logic              dc_rec_en,
    output logic [ADDR_W-1:0] dc_rec_addr,
    output logic [LINE_W-1:0] dc_rec_cacheline,
    output logic              dc_wack,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              ic_full,
    output logic              dc_full,
    output logic              overflow
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] ic_q_addr [QDEPTH];
    logic [PTR_W-1:0]  ic_wptr, ic_rptr;
    logic [CNT_W-1:0]  ic_cnt;

    logic              dc_q_we   [QDEPTH];
    logic [ADDR_W-1:0] dc_q_addr [QDEPTH];
    logic [LINE_W-1:0] dc_q_data [QDEPTH];
    logic [PTR_W-1:0]  dc_wptr, dc_rptr;
    logic [CNT_W-1:0]  dc_cnt;

    logic ic_empty, dc_empty;
    logic grant_ic, grant_dc;
    logic ic_push, ic_pop, ic_drop;
    logic dc_req_any, dc_push, dc_pop, dc_drop;
    logic last_grant_dc, owner_dc, op_we;
    logic resp_fire;

    logic              dc_head_we;
    logic [ADDR_W-1:0] ic_head_addr, dc_head_addr;
    logic [LINE_W-1:0] dc_head_data;

    assign ic_full  = (ic_cnt == FULL_CNT);
    assign dc_full  = (dc_cnt == FULL_CNT);
    assign ic_empty = (ic_cnt == '0);
    assign dc_empty = (dc_cnt == '0);

    assign ic_head_addr = ic_q_addr[ic_rptr];
    assign dc_head_we   = dc_q_we[dc_rptr];
    assign dc_head_addr = dc_q_addr[dc_rptr];
    assign dc_head_data = dc_q_data[dc_rptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO that is being popped still lands.
    assign ic_pop     = grant_ic;
    assign dc_pop     = grant_dc;
    assign ic_push    = ic_req_ren && (!ic_full || ic_pop);
    assign ic_drop    = ic_req_ren && ic_full && !ic_pop;
    assign dc_req_any = dc_req_ren || dc_req_wen;
    assign dc_push    = dc_req_any && (!dc_full || dc_pop);
    assign dc_drop    = (dc_req_any && dc_full && !dc_pop) || (dc_req_ren && dc_req_wen);

    assign resp_fire = (state == ST_WAIT) && mem_ack;

    always_comb begin
        state_next = state;
        grant_ic   = 1'b0;
        grant_dc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ic_empty && !dc_empty) begin
                    grant_ic = last_grant_dc;
                    grant_dc = !last_grant_dc;
                end else begin
                    grant_ic = !ic_empty;
                    grant_dc = !dc_empty;
                end
                if (grant_ic || grant_dc) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Queue storage carries no reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (ic_push) begin
            ic_q_addr[ic_wptr] <= ic_req_addr;
        end
        if (dc_push) begin
            dc_q_we[dc_wptr]   <= dc_req_wen;
            dc_q_addr[dc_wptr] <= dc_req_addr;
            dc_q_data[dc_wptr] <= dc_req_cacheline;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ic_wptr <= '0;
            ic_rptr <= '0;
            ic_cnt  <= '0;
            dc_wptr <= '0;
            dc_rptr <= '0;
            dc_cnt  <= '0;
        end else begin
            if (ic_push) ic_wptr <= ic_wptr + PTR_W'(1);
            if (ic_pop)  ic_rptr <= ic_rptr + PTR_W'(1);
            if (dc_push) dc_wptr <= dc_wptr + PTR_W'(1);
            if (dc_pop)  dc_rptr <= dc_rptr + PTR_W'(1);
            case ({ic_push, ic_pop})
                2'b10:   ic_cnt <= ic_cnt + CNT_W'(1);
                2'b01:   ic_cnt <= ic_cnt - CNT_W'(1);
                default: ic_cnt <= ic_cnt;
            endcase
            case ({dc_push, dc_pop})
                2'b10:   dc_cnt <= dc_cnt + CNT_W'(1);
                2'b01:   dc_cnt <= dc_cnt - CNT_W'(1);
                default: dc_cnt <= dc_cnt;
            endcase
        end
    end

    // mem_addr holds the in-flight address until the next grant, so it doubles as the response address.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ren       <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            owner_dc      <= 1'b0;
            op_we         <= 1'b0;
            last_grant_dc <= 1'b1;
        end else begin
            mem_ren <= grant_ic || (grant_dc && !dc_head_we);
            mem_wen <= grant_dc && dc_head_we;
            if (grant_ic) begin
                mem_addr      <= ic_head_addr;
                mem_wdata     <= '0;
                owner_dc      <= 1'b0;
                op_we         <= 1'b0;
                last_grant_dc <= 1'b0;
            end else if (grant_dc) begin
                mem_addr      <= dc_head_addr;
                mem_wdata     <= dc_head_data;
                owner_dc      <= 1'b1;
                op_we         <= dc_head_we;
                last_grant_dc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ic_rec_en        <= 1'b0;
            ic_rec_addr      <= '0;
            ic_rec_cacheline <= '0;
            dc_rec_en        <= 1'b0;
            dc_rec_addr      <= '0;
            dc_rec_cacheline <= '0;
            dc_wack          <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            ic_rec_en <= resp_fire && !owner_dc;
            dc_rec_en <= resp_fire && owner_dc && !op_we;
            dc_wack   <= resp_fire && owner_dc && op_we;
            if (resp_fire && !owner_dc) begin
                ic_rec_addr      <= mem_addr;
                ic_rec_cacheline <= mem_rdata;
            end
            if (resp_fire && owner_dc && !op_we) begin
                dc_rec_addr      <= mem_addr;
                dc_rec_cacheline <= mem_rdata;
            end
            if (ic_drop || dc_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus a few hand-written sequences.
module tb_mem_arbiter;

    localparam int QDEPTH = 2;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [4:0] P0 = 5'b00000;
    localparam logic [4:0] PR = 5'b10000;
    localparam logic [4:0] PW = 5'b01000;
    localparam logic [4:0] PI = 5'b00100;
    localparam logic [4:0] PD = 5'b00010;
    localparam logic [4:0] PK = 5'b00001;

    localparam logic [LINE_W-1:0] D1  = {8{32'h1111_0001}};
    localparam logic [LINE_W-1:0] D2  = {8{32'h2222_0002}};
    localparam logic [LINE_W-1:0] D3  = {8{32'h3333_0003}};
    localparam logic [LINE_W-1:0] D4  = {8{32'h4444_0004}};
    localparam logic [LINE_W-1:0] D5  = {8{32'h5555_0005}};
    localparam logic [LINE_W-1:0] D6  = {8{32'h6666_0006}};
    localparam logic [LINE_W-1:0] D7  = {8{32'h7777_0007}};
    localparam logic [LINE_W-1:0] D8  = {8{32'h8888_0008}};
    localparam logic [LINE_W-1:0] D9  = {8{32'h9999_0009}};
    localparam logic [LINE_W-1:0] D10 = {8{32'hAAAA_000A}};
    localparam logic [LINE_W-1:0] D11 = {8{32'hBBBB_000B}};
    localparam logic [LINE_W-1:0] D12 = {8{32'hCCCC_000C}};
    localparam logic [LINE_W-1:0] D13 = {8{32'hDDDD_000D}};
    localparam logic [LINE_W-1:0] D14 = {8{32'hEEEE_000E}};
    localparam logic [LINE_W-1:0] W1  = {8{32'hCAFE_F00D}};
    localparam logic [LINE_W-1:0] W2  = {8{32'hBEEF_0123}};

    typedef struct {
        string             name;
        logic              rst;
        logic              ic_ren;
        logic              dc_ren;
        logic              dc_wen;
        logic [ADDR_W-1:0] ic_addr;
        logic [ADDR_W-1:0] dc_addr;
        logic              ack;
        logic [LINE_W-1:0] data;
        logic [4:0]        e_pulse;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_data;
        logic              e_ovf;
        logic [1:0]        e_full;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ic_req_ren;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_rec_en;
    logic [ADDR_W-1:0] ic_rec_addr;
    logic [LINE_W-1:0] ic_rec_cacheline;
    logic              dc_req_ren;
    logic              dc_req_wen;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [LINE_W-1:0] dc_req_cacheline;
    logic              dc_rec_en;
    logic [ADDR_W-1:0] dc_rec_addr;
    logic [LINE_W-1:0] dc_rec_cacheline;
    logic              dc_wack;
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;
    logic              ic_full;
    logic              dc_full;
    logic              overflow;

    int   nVectors = 0;
    int   nMiscompares = 0;
    vec_t tbl[$];

    mem_arbiter #(.QDEPTH(QDEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .ic_req_ren(ic_req_ren), .ic_req_addr(ic_req_addr),
        .ic_rec_en(ic_rec_en), .ic_rec_addr(ic_rec_addr), .ic_rec_cacheline(ic_rec_cacheline),
        .dc_req_ren(dc_req_ren), .dc_req_wen(dc_req_wen), .dc_req_addr(dc_req_addr),
        .dc_req_cacheline(dc_req_cacheline),
        .dc_rec_en(dc_rec_en), .dc_rec_addr(dc_rec_addr), .dc_rec_cacheline(dc_rec_cacheline),
        .dc_wack(dc_wack),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ic_full(ic_full), .dc_full(dc_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic r, logic ic, logic dr, logic dw,
                                logic [ADDR_W-1:0] ica, logic [ADDR_W-1:0] dca,
                                logic ak, logic [LINE_W-1:0] d, logic [4:0] ep,
                                logic [ADDR_W-1:0] ea, logic [LINE_W-1:0] ed,
                                logic eo, logic [1:0] ef);
        vec_t v;
        v.name = n;   v.rst = r;     v.ic_ren = ic; v.dc_ren = dr; v.dc_wen = dw;
        v.ic_addr = ica; v.dc_addr = dca; v.ack = ak; v.data = d;
        v.e_pulse = ep; v.e_addr = ea; v.e_data = ed; v.e_ovf = eo; v.e_full = ef;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst              = v.rst;
        ic_req_ren       = v.ic_ren;
        ic_req_addr      = v.ic_addr;
        dc_req_ren       = v.dc_ren;
        dc_req_wen       = v.dc_wen;
        dc_req_addr      = v.dc_addr;
        dc_req_cacheline = v.data;
        mem_ack          = v.ack;
        mem_rdata        = v.data;
    endtask

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v);
        logic [4:0] pulses;
        pulses = {mem_ren, mem_wen, ic_rec_en, dc_rec_en, dc_wack};
        checkOutput({v.name, " pulses"}, LINE_W'(pulses), LINE_W'(v.e_pulse));
        if (v.e_pulse[4] || v.e_pulse[3])
            checkOutput({v.name, " mem_addr"}, LINE_W'(mem_addr), LINE_W'(v.e_addr));
        if (v.e_pulse[3])
            checkOutput({v.name, " mem_wdata"}, mem_wdata, v.e_data);
        if (v.e_pulse[2]) begin
            checkOutput({v.name, " ic_rec_addr"}, LINE_W'(ic_rec_addr), LINE_W'(v.e_addr));
            checkOutput({v.name, " ic_rec_line"}, ic_rec_cacheline, v.e_data);
        end
        if (v.e_pulse[1]) begin
            checkOutput({v.name, " dc_rec_addr"}, LINE_W'(dc_rec_addr), LINE_W'(v.e_addr));
            checkOutput({v.name, " dc_rec_line"}, dc_rec_cacheline, v.e_data);
        end
        checkOutput({v.name, " overflow"}, LINE_W'(overflow), LINE_W'(v.e_ovf));
        checkOutput({v.name, " full"}, LINE_W'({ic_full, dc_full}), LINE_W'(v.e_full));
    endtask

    // Each row is one clock cycle; expectations are what the outputs show during that cycle.
    initial begin
        tbl.push_back(mk("A0", 0,1,0,0, 32'h1040,0, 0,0,   P0,0,0,0,2'b00));
        tbl.push_back(mk("A1", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("A2", 0,0,0,0, 0,0, 0,0,          PR,32'h1040,0,0,2'b00));
        tbl.push_back(mk("A3", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("A4", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("A5", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("A6", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("A7", 0,0,0,0, 0,0, 1,D1,         P0,0,0,0,2'b00));
        tbl.push_back(mk("A8", 0,0,0,0, 0,0, 0,0,          PI,32'h1040,D1,0,2'b00));
        tbl.push_back(mk("B0", 1,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("B1", 0,1,1,0, 32'h100,32'h200, 0,0, P0,0,0,0,2'b00));
        tbl.push_back(mk("B2", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("B3", 0,1,1,0, 32'h110,32'h210, 0,0, PR,32'h100,0,0,2'b00));
        tbl.push_back(mk("B4", 0,0,0,0, 0,0, 1,D2,         P0,0,0,0,2'b01));
        tbl.push_back(mk("B5", 0,0,0,0, 0,0, 0,0,          PI,32'h100,D2,0,2'b01));
        tbl.push_back(mk("B6", 0,0,0,0, 0,0, 1,D3,         PR,32'h200,0,0,2'b00));
        tbl.push_back(mk("B7", 0,0,0,0, 0,0, 0,0,          PD,32'h200,D3,0,2'b00));
        tbl.push_back(mk("B8", 0,0,0,0, 0,0, 1,D4,         PR,32'h110,0,0,2'b00));
        tbl.push_back(mk("B9", 0,0,0,0, 0,0, 0,0,          PI,32'h110,D4,0,2'b00));
        tbl.push_back(mk("B10",0,0,0,0, 0,0, 0,0,          PR,32'h210,0,0,2'b00));
        tbl.push_back(mk("B11",0,0,0,0, 0,0, 1,D5,         P0,0,0,0,2'b00));
        tbl.push_back(mk("B12",0,0,0,0, 0,0, 0,0,          PD,32'h210,D5,0,2'b00));
        tbl.push_back(mk("C0", 0,0,0,1, 0,32'h300, 0,W1,   P0,0,0,0,2'b00));
        tbl.push_back(mk("C1", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("C2", 0,0,0,0, 0,0, 0,0,          PW,32'h300,W1,0,2'b00));
        tbl.push_back(mk("C3", 0,0,0,0, 0,0, 1,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("C4", 0,0,0,0, 0,0, 0,0,          PK,0,0,0,2'b00));
        tbl.push_back(mk("D0", 0,1,0,0, 32'h400,0, 0,0,    P0,0,0,0,2'b00));
        tbl.push_back(mk("D1", 0,1,0,0, 32'h410,0, 0,0,    P0,0,0,0,2'b00));
        tbl.push_back(mk("D2", 0,1,0,0, 32'h420,0, 0,0,    PR,32'h400,0,0,2'b00));
        tbl.push_back(mk("D3", 0,1,0,0, 32'h430,0, 0,0,    P0,0,0,0,2'b10));
        tbl.push_back(mk("D4", 0,0,0,0, 0,0, 1,D6,         P0,0,0,1,2'b10));
        tbl.push_back(mk("D5", 0,0,0,0, 0,0, 0,0,          PI,32'h400,D6,1,2'b10));
        tbl.push_back(mk("D6", 0,0,0,0, 0,0, 1,D7,         PR,32'h410,0,1,2'b00));
        tbl.push_back(mk("D7", 0,0,0,0, 0,0, 0,0,          PI,32'h410,D7,1,2'b00));
        tbl.push_back(mk("D8", 0,0,0,0, 0,0, 1,D8,         PR,32'h420,0,1,2'b00));
        tbl.push_back(mk("D9", 0,0,0,0, 0,0, 0,0,          PI,32'h420,D8,1,2'b00));
        tbl.push_back(mk("D10",0,0,0,0, 0,0, 0,0,          P0,0,0,1,2'b00));
        tbl.push_back(mk("D11",0,0,0,0, 0,0, 0,0,          P0,0,0,1,2'b00));
        tbl.push_back(mk("E0", 1,0,0,0, 0,0, 0,0,          P0,0,0,1,2'b00));
        tbl.push_back(mk("E1", 0,0,1,0, 0,32'h500, 0,0,    P0,0,0,0,2'b00));
        tbl.push_back(mk("E2", 0,0,1,0, 0,32'h510, 0,0,    P0,0,0,0,2'b00));
        tbl.push_back(mk("E3", 0,0,1,0, 0,32'h520, 0,0,    PR,32'h500,0,0,2'b00));
        tbl.push_back(mk("E4", 0,0,0,0, 0,0, 1,D9,         P0,0,0,0,2'b01));
        tbl.push_back(mk("E5", 0,0,1,0, 0,32'h530, 0,0,    PD,32'h500,D9,0,2'b01));
        tbl.push_back(mk("E6", 0,0,0,0, 0,0, 0,0,          PR,32'h510,0,0,2'b01));
        tbl.push_back(mk("E7", 0,0,0,0, 0,0, 1,D10,        P0,0,0,0,2'b01));
        tbl.push_back(mk("E8", 0,0,0,0, 0,0, 0,0,          PD,32'h510,D10,0,2'b01));
        tbl.push_back(mk("E9", 0,0,0,0, 0,0, 1,D11,        PR,32'h520,0,0,2'b00));
        tbl.push_back(mk("E10",0,0,0,0, 0,0, 0,0,          PD,32'h520,D11,0,2'b00));
        tbl.push_back(mk("E11",0,0,1,0, 0,32'h540, 0,0,    PR,32'h530,0,0,2'b00));
        tbl.push_back(mk("F0", 1,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("F1", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("F2", 0,0,0,0, 0,0, 1,D12,        P0,0,0,0,2'b00));
        tbl.push_back(mk("F3", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("F4", 0,1,0,0, 32'h600,0, 0,0,    P0,0,0,0,2'b00));
        tbl.push_back(mk("F5", 0,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("F6", 0,0,0,0, 0,0, 1,D13,        PR,32'h600,0,0,2'b00));
        tbl.push_back(mk("F7", 0,0,0,0, 0,0, 0,0,          PI,32'h600,D13,0,2'b00));
        tbl.push_back(mk("G0", 1,0,0,0, 0,0, 0,0,          P0,0,0,0,2'b00));
        tbl.push_back(mk("G1", 0,0,1,1, 0,32'h700, 0,W2,   P0,0,0,0,2'b00));
        tbl.push_back(mk("G2", 0,0,0,0, 0,0, 0,0,          P0,0,0,1,2'b00));
        tbl.push_back(mk("G3", 0,0,0,0, 0,0, 0,0,          PW,32'h700,W2,1,2'b00));
        tbl.push_back(mk("G4", 0,0,0,0, 0,0, 1,0,          P0,0,0,1,2'b00));
        tbl.push_back(mk("G5", 0,0,0,0, 0,0, 0,0,          PK,0,0,1,2'b00));
        tbl.push_back(mk("G6", 0,0,0,0, 0,0, 0,0,          P0,0,0,1,2'b00));

        rst = 1'b1; ic_req_ren = 1'b0; ic_req_addr = '0; dc_req_ren = 1'b0;
        dc_req_wen = 1'b0; dc_req_addr = '0; dc_req_cacheline = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset values of every registered output.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst pulses", LINE_W'({mem_ren, mem_wen, ic_rec_en, dc_rec_en, dc_wack}), '0);
        checkOutput("rst mem_addr", LINE_W'(mem_addr), '0);
        checkOutput("rst mem_wdata", mem_wdata, '0);
        checkOutput("rst ic_rec_addr", LINE_W'(ic_rec_addr), '0);
        checkOutput("rst ic_rec_line", ic_rec_cacheline, '0);
        checkOutput("rst dc_rec_addr", LINE_W'(dc_rec_addr), '0);
        checkOutput("rst dc_rec_line", dc_rec_cacheline, '0);
        checkOutput("rst overflow", LINE_W'(overflow), '0);
        checkOutput("rst full", LINE_W'({ic_full, dc_full}), '0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkVector(tbl[i]);
        end

        // An ack with nothing in flight must not produce a response.
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = D14;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack pulses", LINE_W'({mem_ren, mem_wen, ic_rec_en, dc_rec_en, dc_wack}), '0);

        // Fresh dcache read with bounded waits on the command and the response.
        @(posedge clk); #1; dc_req_ren = 1'b1; dc_req_addr = 32'h800; dc_req_cacheline = '0;
        @(posedge clk); #1; dc_req_ren = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (mem_ren) seen = 1'b1;
                else @(posedge clk);
            end
            checkOutput("final mem_ren seen", LINE_W'(seen), LINE_W'(1));
            checkOutput("final mem_addr", LINE_W'(mem_addr), LINE_W'(32'h800));
            @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = D14;
            @(posedge clk); #1; mem_ack = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (dc_rec_en) seen = 1'b1;
                else @(posedge clk);
            end
            checkOutput("final dc_rec seen", LINE_W'(seen), LINE_W'(1));
            checkOutput("final dc_rec_addr", LINE_W'(dc_rec_addr), LINE_W'(32'h800));
            checkOutput("final dc_rec_line", dc_rec_cacheline, D14);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
